// File: rtl/unidade_entrada.sv
// rtl/unidade_entrada.sv - switch capture stage feeding the register bank write port
// Waits for a debounced confirm press, then writes the extended switches to the destination register.
module unidade_entrada #(
  parameter int LARGURA_SWITCH  = 16,
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int SINAL           = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LARGURA_SWITCH-1:0] switches,
  input  logic                      botaoConfirma,
  input  logic                      requisicaoEntrada,
  input  logic [4:0]                enderecoDestino,
  output logic [31:0]               dadoEntrada,
  output logic [4:0]                enderecoEscritaEntrada,
  output logic                      escritaEntrada,
  output logic                      estagioEntradaSwitch,
  output logic                      aguardandoEntrada,
  output logic                      entradaConcluida
);

  localparam int LARGURA_CONT = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [LARGURA_CONT-1:0] CONT_MAX = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);
  localparam bit ESTENDE_SINAL = (SINAL != 0);

  typedef enum logic [2:0] {
    OCIOSO,
    AGUARDA_SOLTAR,
    AGUARDA_PRESSAO,
    ESCREVE,
    CONCLUI,
    AGUARDA_BAIXA
  } estado_t;

  estado_t                 estado;
  logic                    botaoSync1;
  logic                    botaoSync2;
  logic                    botaoEstavel;
  logic [LARGURA_CONT-1:0] contador;
  logic [31:0]             switchesEstendidos;

  generate
    if (LARGURA_SWITCH == 32) begin : gSemExtensao
      assign switchesEstendidos = switches;
    end else begin : gExtensao
      logic bitTopo;
      assign bitTopo = ESTENDE_SINAL ? switches[LARGURA_SWITCH-1] : 1'b0;
      assign switchesEstendidos = {{(32-LARGURA_SWITCH){bitTopo}}, switches};
    end
  endgenerate

  // The button idles high (released); both stages reset to the released level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botaoSync1 <= 1'b1;
      botaoSync2 <= 1'b1;
    end else begin
      botaoSync1 <= botaoConfirma;
      botaoSync2 <= botaoSync1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botaoEstavel <= 1'b1;
      contador     <= '0;
    end else if (botaoSync2 == botaoEstavel) begin
      contador <= '0;
    end else if (contador == CONT_MAX) begin
      botaoEstavel <= botaoSync2;
      contador     <= '0;
    end else begin
      contador <= contador + 1'b1;
    end
  end

  // Outputs are set on the transition into the state that owns them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado                 <= OCIOSO;
      dadoEntrada            <= '0;
      enderecoEscritaEntrada <= '0;
      escritaEntrada         <= 1'b0;
      estagioEntradaSwitch   <= 1'b0;
      aguardandoEntrada      <= 1'b0;
      entradaConcluida       <= 1'b0;
    end else begin
      escritaEntrada       <= 1'b0;
      estagioEntradaSwitch <= 1'b0;
      entradaConcluida     <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (requisicaoEntrada) begin
            aguardandoEntrada <= 1'b1;
            estado            <= botaoEstavel ? AGUARDA_PRESSAO : AGUARDA_SOLTAR;
          end
        end
        AGUARDA_SOLTAR: begin
          if (!requisicaoEntrada) begin
            aguardandoEntrada <= 1'b0;
            estado            <= OCIOSO;
          end else if (botaoEstavel) begin
            estado <= AGUARDA_PRESSAO;
          end
        end
        AGUARDA_PRESSAO: begin
          if (!requisicaoEntrada) begin
            aguardandoEntrada <= 1'b0;
            estado            <= OCIOSO;
          end else if (!botaoEstavel) begin
            dadoEntrada            <= switchesEstendidos;
            enderecoEscritaEntrada <= enderecoDestino;
            escritaEntrada         <= 1'b1;
            estagioEntradaSwitch   <= 1'b1;
            aguardandoEntrada      <= 1'b0;
            estado                 <= ESCREVE;
          end
        end
        ESCREVE: begin
          entradaConcluida <= 1'b1;
          estado           <= CONCLUI;
        end
        CONCLUI: begin
          estado <= AGUARDA_BAIXA;
        end
        AGUARDA_BAIXA: begin
          if (!requisicaoEntrada) estado <= OCIOSO;
        end
        default: begin
          aguardandoEntrada <= 1'b0;
          estado            <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_entrada.sv
// tb/tb_unidade_entrada.sv - scoreboard bench for unidade_entrada, zero- and sign-extending instances
module tb_unidade_entrada;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] switches;
  logic        botaoConfirma;
  logic        requisicaoEntrada;
  logic [4:0]  enderecoDestino;

  logic [31:0] dado0, dado1;
  logic [4:0]  end0, end1;
  logic        esc0, esc1, est0, est1, agu0, agu1, con0, con1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] sw;
    logic [4:0]  addr;
  } esperado_t;
  esperado_t fila[$];

  always #5 clock = ~clock;

  unidade_entrada #(.LARGURA_SWITCH(16), .DEBOUNCE_CICLOS(4), .SINAL(0)) dutZero (
    .clock(clock), .reset(reset), .switches(switches), .botaoConfirma(botaoConfirma),
    .requisicaoEntrada(requisicaoEntrada), .enderecoDestino(enderecoDestino),
    .dadoEntrada(dado0), .enderecoEscritaEntrada(end0), .escritaEntrada(esc0),
    .estagioEntradaSwitch(est0), .aguardandoEntrada(agu0), .entradaConcluida(con0)
  );

  unidade_entrada #(.LARGURA_SWITCH(16), .DEBOUNCE_CICLOS(4), .SINAL(1)) dutSinal (
    .clock(clock), .reset(reset), .switches(switches), .botaoConfirma(botaoConfirma),
    .requisicaoEntrada(requisicaoEntrada), .enderecoDestino(enderecoDestino),
    .dadoEntrada(dado1), .enderecoEscritaEntrada(end1), .escritaEntrada(esc1),
    .estagioEntradaSwitch(est1), .aguardandoEntrada(agu1), .entradaConcluida(con1)
  );

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
    end
  endtask

  function automatic logic [31:0] zeroExt(input logic [15:0] sw);
    int v;
    v = int'(sw);
    return 32'(v);
  endfunction

  function automatic logic [31:0] signExt(input logic [15:0] sw);
    int v;
    v = int'(sw);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  // Scoreboard monitor: every write must match the oldest expected capture.
  logic escritaAnterior = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      escritaAnterior = 1'b0;
    end else begin
      if (esc0 || est0 || esc1) begin
        check("estagio_with_write", {31'b0, est0}, {31'b0, esc0});
        check("write_instances_agree", {31'b0, esc1}, {31'b0, esc0});
        if (fila.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got data 0x%0h addr %0d expected no write", dado0, end0);
        end else begin
          esperado_t e;
          e = fila.pop_front();
          check("data_zero_ext", dado0, zeroExt(e.sw));
          check("data_sign_ext", dado1, signExt(e.sw));
          check("addr_zero_inst", {27'b0, end0}, {27'b0, e.addr});
          check("addr_sign_inst", {27'b0, end1}, {27'b0, e.addr});
        end
      end
      if (escritaAnterior || con0 || con1) begin
        check("concluida_after_write", {31'b0, con0}, {31'b0, escritaAnterior});
        check("concluida_sign_inst", {31'b0, con1}, {31'b0, escritaAnterior});
      end
      escritaAnterior = esc0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Counts rising edges, starting with the one that first samples the press.
  task automatic waitWrite(input string nome, input int esperado);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!esc0 && n < 40);
    check(nome, n, esperado);
  endtask

  task automatic pushCapture(input logic [15:0] sw, input logic [4:0] addr);
    esperado_t e;
    e.sw   = sw;
    e.addr = addr;
    fila.push_back(e);
  endtask

  task automatic settle();
    requisicaoEntrada = 1'b0;
    botaoConfirma     = 1'b1;
    tick(12);
  endtask

  task automatic basicWrite(input logic [15:0] sw, input logic [4:0] addr, input string nome);
    switches          = sw;
    enderecoDestino   = addr;
    requisicaoEntrada = 1'b1;
    tick(1);
    check({nome, "_aguardando_rise"}, {31'b0, agu0}, 32'd1);
    pushCapture(sw, addr);
    botaoConfirma = 1'b0;
    waitWrite({nome, "_latency"}, 7);
    check({nome, "_aguardando_low"}, {31'b0, agu0}, 32'd0);
    tick(18);
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset             = 1'b0;
    switches          = 16'h0;
    botaoConfirma     = 1'b1;
    requisicaoEntrada = 1'b0;
    enderecoDestino   = 5'd0;
    tick(3);
    @(negedge clock);
    check("reset_dado", dado0, 32'd0);
    check("reset_endereco", {27'b0, end0}, 32'd0);
    check("reset_outputs", {28'b0, esc0, est0, agu0, con0}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick(2);

    basicWrite(16'h00A5, 5'd5, "basic");

    // Bounce: toggles shorter than the debounce window, then a clean press.
    requisicaoEntrada = 1'b1;
    enderecoDestino   = 5'd9;
    switches          = 16'($urandom);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      botaoConfirma = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    check("bounce_still_waiting", {31'b0, agu0}, 32'd1);
    pushCapture(switches, 5'd9);
    botaoConfirma = 1'b0;
    waitWrite("bounce_latency", 7);
    tick(3);
    settle();

    // Button already held when the request arrives.
    botaoConfirma = 1'b0;
    tick(10);
    switches          = 16'h8001;
    enderecoDestino   = 5'd31;
    requisicaoEntrada = 1'b1;
    tick(1);
    check("held_aguardando", {31'b0, agu0}, 32'd1);
    tick(8);
    check("held_still_waiting", {31'b0, agu0}, 32'd1);
    botaoConfirma = 1'b1;
    tick(10);
    check("released_still_waiting", {31'b0, agu0}, 32'd1);
    pushCapture(16'h8001, 5'd31);
    botaoConfirma = 1'b0;
    waitWrite("held_repress_latency", 7);
    @(negedge clock);
    #1;
    check("sign_ext_8001", dado1, 32'hFFFF8001);
    check("zero_ext_8001", dado0, 32'h00008001);
    settle();

    // Abort while waiting, then presses with no request pending.
    requisicaoEntrada = 1'b1;
    tick(2);
    check("abort_waiting", {31'b0, agu0}, 32'd1);
    requisicaoEntrada = 1'b0;
    tick(1);
    check("abort_idle", {31'b0, agu0}, 32'd0);
    botaoConfirma = 1'b0;
    tick(10);
    botaoConfirma = 1'b1;
    tick(10);
    check("idle_press_no_wait", {31'b0, agu0}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      logic [15:0] sw;
      logic [4:0]  addr;
      int nb;
      sw   = 16'($urandom);
      addr = 5'($urandom);
      switches          = sw;
      enderecoDestino   = addr;
      requisicaoEntrada = 1'b1;
      tick(1);
      nb = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) begin
        botaoConfirma = 1'b0;
        tick($urandom_range(1, 2));
        botaoConfirma = 1'b1;
        tick($urandom_range(1, 2));
      end
      pushCapture(sw, addr);
      botaoConfirma = 1'b0;
      waitWrite("random_latency", 7);
      tick(3);
      check("random_done_not_waiting", {31'b0, agu0}, 32'd0);
      settle();
    end

    // Reset asserted asynchronously inside the write cycle.
    switches          = 16'h1234;
    enderecoDestino   = 5'd7;
    requisicaoEntrada = 1'b1;
    tick(1);
    pushCapture(16'h1234, 5'd7);
    botaoConfirma = 1'b0;
    waitWrite("pre_reset_latency", 7);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_dado", dado0, 32'd0);
    check("async_reset_endereco", {27'b0, end0}, 32'd0);
    check("async_reset_outputs", {28'b0, esc0, est0, agu0, con0}, 32'd0);
    requisicaoEntrada = 1'b0;
    botaoConfirma     = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    check("post_reset_idle", {31'b0, agu0}, 32'd0);
    basicWrite(16'h00A5, 5'd5, "post_reset");

    check("scoreboard_empty", fila.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
